// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding,
// terminator word and default geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_HI = 3'd1,
    ST_LOAD_LO = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [15:0]  TERM_WORD   = 16'hFFFF;
  localparam int unsigned  DEF_ADDR_W  = 6;
  localparam int unsigned  DEF_DEPTH   = 64;

endpackage

// File: rtl/imem_loader.sv
// Assembles a big-endian byte stream into 16-bit words, writes them to
// instruction memory from address 0, and holds the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter logic [15:0] TERM   = TERM_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [15:0]       checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [15:0]         sum_q, sum_d;
  logic                xfer;
  logic [15:0]         word;

  assign in_ready = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
  assign xfer     = in_valid && in_ready;
  assign word     = {hi_q, in_data};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        we_d = 1'b0;
        if (start) begin
          state_d   = ST_LOAD_HI;
          addr_d    = '0;
          cnt_d     = '0;
          sum_d     = '0;
          ovf_d     = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end

      ST_LOAD_HI: begin
        if (xfer) begin
          hi_d    = in_data;
          state_d = ST_LOAD_LO;
        end
      end

      ST_LOAD_LO: begin
        if (xfer) begin
          wdata_d = word;
          we_d    = 1'b1;
          sum_d   = sum_q ^ word;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // The write itself happens this cycle; decide where to go next.
        we_d  = 1'b0;
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (wdata_q == TERM || addr_q == LAST_ADDR) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
          ovf_d     = (wdata_q != TERM);
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_LOAD_HI;
        end
      end

      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = cnt_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected memory writes are
// queued as bytes are issued and checked by an independent write monitor.
module tb_imem_loader;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam logic [15:0] TERM  = 16'hFFFF;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, cpu_rst, busy, done, overflow;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata, checksum;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .DEPTH(DEPTH), .TERM(TERM)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .overflow(overflow), .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  wr_t         sb_q[$];
  wr_t         mon_e;
  int unsigned we_pulses = 0;
  logic        we_prev = 1'b0;
  logic [7:0]  stim[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (rst) begin
      we_prev = 1'b0;
    end else begin
      if (imem_we) begin
        we_pulses++;
        chk("we_single_cycle", 32'(we_prev), 32'd0);
        chk("in_ready_in_write", 32'(in_ready), 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb_q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(imem_wdata), 32'(mon_e.data));
        end
      end
      we_prev = imem_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned waited = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("byte_accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_count", 32'(word_count), 32'd0);
    chk("start_checksum", 32'(checksum), 32'd0);
    chk("start_overflow", 32'(overflow), 32'd0);
    chk("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Reference model: pairs bytes into big-endian words, addresses them from
  // zero, and stops at the terminator or after DEPTH words.
  task automatic do_load(input int unsigned gap_mode, input int start_lo_at);
    logic [15:0] w;
    logic [15:0] exp_sum = '0;
    int unsigned idx = 0;
    int unsigned g;
    bit ended = 1'b0;
    bit ovf = 1'b0;
    pulse_start();
    we_pulses = 0;
    for (int i = 0; i < stim.size() && !ended; i++) begin
      if (i % 2 == 1) begin
        w = {stim[i-1], stim[i]};
        sb_q.push_back('{addr: AW'(idx), data: w});
        exp_sum ^= w;
        idx++;
        if (w == TERM) ended = 1'b1;
        else if (idx == DEPTH) begin ended = 1'b1; ovf = 1'b1; end
      end
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : $urandom_range(0, 4);
      send_byte(stim[i], g);
      if (i == start_lo_at) begin
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("start_ignored_in_lo", {30'd0, in_ready, busy}, 32'd3);
      end
    end
    in_valid = 1'b0;
    if (ended) begin
      chk("write_cycle_we", 32'(imem_we), 32'd1);
      chk("write_cycle_cpu_rst", 32'(cpu_rst), 32'd1);
      tick();
      chk("end_done", 32'(done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("end_overflow", 32'(overflow), 32'(ovf));
      chk("end_word_count", 32'(word_count), idx);
      chk("end_checksum", 32'(checksum), 32'(exp_sum));
      chk("end_in_ready", 32'(in_ready), 32'd0);
      chk("end_sb_empty", sb_q.size(), 32'd0);
      chk("end_we_pulses", we_pulses, idx);
    end else begin
      tick();
      chk("partial_word_count", 32'(word_count), idx);
      chk("partial_busy", 32'(busy), 32'd1);
      chk("partial_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("partial_sb_empty", sb_q.size(), 32'd0);
    end
  endtask

  task automatic done_hold();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      chk("done_hold", {29'd0, in_ready, done, cpu_rst}, 32'b010);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int unsigned n;
    logic [15:0] w;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_flags", {29'd0, busy, done, overflow}, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_with_rst", {30'd0, busy, in_ready}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      chk("idle_safe", {29'd0, in_ready, imem_we, cpu_rst}, 32'b001);
    end
    in_valid = 1'b0;

    stim = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
    do_load(0, -1);
    chk("basic_checksum", 32'(checksum), 32'h4606);
    done_hold();

    do_load(1, 2);
    chk("gap_checksum", 32'(checksum), 32'h4606);

    stim.delete();
    for (int i = 0; i < 64; i++) begin stim.push_back(8'h00); stim.push_back(8'h01); end
    do_load(0, -1);

    stim.delete();
    for (int i = 0; i < 63; i++) begin stim.push_back(8'h00); stim.push_back(8'h01); end
    stim.push_back(8'hFF); stim.push_back(8'hFF);
    do_load(2, -1);

    stim = '{8'hFF, 8'hFF};
    do_load(0, -1);

    stim = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h56};
    do_load(0, -1);
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(word_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    stim = '{8'h00, 8'h07, 8'hFF, 8'hFF};
    do_load(0, -1);

    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 10);
      stim.delete();
      for (int k = 0; k + 1 < int'(n); k++) begin
        w = 16'($urandom);
        if (w == TERM) w = 16'h1234;
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
      end
      stim.push_back(8'hFF); stim.push_back(8'hFF);
      do_load(2, (t % 2 == 0) ? 0 : -1);
    end

    repeat (3) tick();
    chk("final_sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
